shift_sequencer: RTL

//   Multi-step shift engine. Upstream of the single-step shift stage: it accepts an operand, op code and shift

---
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for the multi-step shift engine.
// slave is the engine side, master is the requester/consumer side.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_op, in_amt, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_op, in_amt, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-step shift engine: applies a one-bit shift/rotate step
// once per clock, amt times, then offers the result downstream.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] data;
  logic [2:0]       op;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] res;
  logic             rdy;
  logic             vld;
  logic [WIDTH-1:0] stepped;

  // op: [0]=left, [1]=logical, [2]=rotate
  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       o
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (1'b1)
      o[2] & o[0]:
        r = {d[WIDTH-2:0], d[WIDTH-1]};
      o[2] & !o[0]:
        r = {d[0], d[WIDTH-1:1]};
      !o[2] & o[0]:
        r = {d[WIDTH-2:0], 1'b0};
      !o[2] & !o[0] & o[1]:
        r = {1'b0, d[WIDTH-1:1]};
      default:
        r = {d[WIDTH-1], d[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign stepped = step(data, op);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid)
          nxt = (bus.in_amt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt == AMT_W'(1)) nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy = 1'b0;
    vld = 1'b0;
    case (state)
      IDLE:    rdy = 1'b1;
      DONE:    vld = 1'b1;
      default: ;
    endcase
  end

  // res is separate from data so the last result survives a new accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      op   <= '0;
      cnt  <= '0;
      res  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data <= bus.in_data;
            op   <= bus.in_op;
            cnt  <= bus.in_amt;
            if (bus.in_amt == '0) res <= bus.in_data;
          end
        end
        SHIFT: begin
          data <= stepped;
          cnt  <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) res <= stepped;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.busy      = !rdy;
  assign bus.out_data  = res;

endmodule
